// File: rtl/board_reloader_pkg.sv
// Shared constants and types for the board reloader: default board geometry,
// tile codes and the reload FSM state encoding.
package board_reloader_pkg;

  localparam int BR_BOARD_W  = 28;
  localparam int BR_BOARD_H  = 31;
  localparam int BR_TILE_W   = 4;
  localparam int BR_NUM_MAPS = 2;

  localparam int TILE_EMPTY = 0;
  localparam int TILE_WALL  = 1;
  localparam int TILE_DOT   = 2;
  localparam int TILE_POWER = 3;
  localparam int TILE_DOOR  = 4;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_FETCH,
    BR_DRAIN,
    BR_DONE
  } br_state_t;

  // Level 1 is the first maze; level 0 is treated like level 1.
  function automatic int br_level_to_map(input logic [7:0] level, input int num_maps);
    return (level == 8'd0) ? 0 : ((int'(level) - 1) % num_maps);
  endfunction

endpackage

// File: rtl/board_copy_pipe.sv
// ROM address sweep plus the delayed write stage. The ROM read takes one
// cycle, so the tile index rides one stage behind the address and the write
// is registered one more stage after that.
module board_copy_pipe
  import board_reloader_pkg::*;
#(
  parameter int N          = BR_BOARD_W * BR_BOARD_H,
  parameter int TILE_W     = BR_TILE_W,
  parameter int ADDR_W     = $clog2(N),
  parameter int ROM_ADDR_W = $clog2(BR_NUM_MAPS * N)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic [ROM_ADDR_W-1:0] i_base,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [TILE_W-1:0]     i_rom_data,
  output logic                  o_last,
  output logic                  o_pending,
  output logic                  o_we,
  output logic [ADDR_W-1:0]     o_waddr,
  output logic [TILE_W-1:0]     o_wdata
);

  // [0] address presented, [1] ROM data valid, [2] RAM write
  logic [2:0]            r_vld_pipe;
  logic [ROM_ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0]     r_idx;
  logic [ADDR_W-1:0]     r_d_idx;
  logic [ADDR_W-1:0]     r_waddr;
  logic [TILE_W-1:0]     r_wdata;
  logic                  w_last;

  assign w_last = r_vld_pipe[0] && (r_idx == ADDR_W'(N - 1));

  // Address sweep, index delay and write register; flush kills all in-flight tiles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_rom_addr <= '0;
      r_idx      <= '0;
      r_d_idx    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else if (i_flush) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[2:1] <= r_vld_pipe[1:0];
      r_d_idx         <= r_idx;
      r_waddr         <= r_d_idx;
      r_wdata         <= i_rom_data;
      if (i_start) begin
        r_vld_pipe[0] <= 1'b1;
        r_rom_addr    <= i_base;
        r_idx         <= '0;
      end else if (r_vld_pipe[0]) begin
        if (w_last) begin
          r_vld_pipe[0] <= 1'b0;
        end else begin
          r_rom_addr <= r_rom_addr + ROM_ADDR_W'(1);
          r_idx      <= r_idx + ADDR_W'(1);
        end
      end
    end
  end

  assign o_rom_addr = r_rom_addr;
  assign o_last     = w_last;
  assign o_pending  = r_vld_pipe[0] | r_vld_pipe[1];
  assign o_we       = r_vld_pipe[2];
  assign o_waddr    = r_waddr;
  assign o_wdata    = r_wdata;

endmodule

// File: rtl/board_reloader.sv
// Board-reload handshake responder: copies the level's maze map from the maze
// ROM into the board RAM, then holds done until the request drops.
// Optional: BOARD_RELOADER_DOT_COUNT_EN adds o_dot_total (dots + power pellets
// written during the copy).
module board_reloader
  import board_reloader_pkg::*;
#(
  parameter  int BOARD_W    = BR_BOARD_W,
  parameter  int BOARD_H    = BR_BOARD_H,
  parameter  int TILE_W     = BR_TILE_W,
  parameter  int NUM_MAPS   = BR_NUM_MAPS,
  localparam int N          = BOARD_W * BOARD_H,
  localparam int ADDR_W     = $clog2(N),
  localparam int ROM_ADDR_W = $clog2(NUM_MAPS * N)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_board_reload,
  input  logic [7:0]            i_level,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [TILE_W-1:0]     i_rom_data,
  output logic                  o_ram_we,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic [TILE_W-1:0]     o_ram_wdata,
  output logic                  o_board_reload_done,
  output logic                  o_busy
`ifdef BOARD_RELOADER_DOT_COUNT_EN
  ,
  output logic [ADDR_W-1:0]     o_dot_total
`endif
);

  br_state_t             r_state, w_state_nxt;
  logic                  w_start, w_flush, w_last, w_pending;
  logic [ROM_ADDR_W-1:0] w_base;

  // The map is only needed to seed the address counter, so level changes
  // after the start edge cannot disturb the copy.
  assign w_base = ROM_ADDR_W'(br_level_to_map(i_level, NUM_MAPS) * N);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= BR_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state; dropping the request mid-copy aborts and flushes the pipe.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      BR_IDLE: if (i_board_reload) begin
        w_start     = 1'b1;
        w_state_nxt = BR_FETCH;
      end
      BR_FETCH: begin
        if (!i_board_reload) begin
          w_flush     = 1'b1;
          w_state_nxt = BR_IDLE;
        end else if (w_last) begin
          w_state_nxt = BR_DRAIN;
        end
      end
      BR_DRAIN: begin
        if (!i_board_reload) begin
          w_flush     = 1'b1;
          w_state_nxt = BR_IDLE;
        end else if (!w_pending) begin
          w_state_nxt = BR_DONE;
        end
      end
      BR_DONE: if (!i_board_reload) w_state_nxt = BR_IDLE;
      default: w_state_nxt = BR_IDLE;
    endcase
  end

  board_copy_pipe #(
    .N(N), .TILE_W(TILE_W), .ADDR_W(ADDR_W), .ROM_ADDR_W(ROM_ADDR_W)
  ) u_pipe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_start),
    .i_flush    (w_flush),
    .i_base     (w_base),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data),
    .o_last     (w_last),
    .o_pending  (w_pending),
    .o_we       (o_ram_we),
    .o_waddr    (o_ram_addr),
    .o_wdata    (o_ram_wdata)
  );

  assign o_board_reload_done = (r_state == BR_DONE);
  assign o_busy              = (r_state == BR_FETCH) || (r_state == BR_DRAIN);

`ifdef BOARD_RELOADER_DOT_COUNT_EN
  logic [ADDR_W-1:0] r_dot_total;

  // Count edible tiles as they are written; restart with each request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dot_total <= '0;
    end else if (w_start) begin
      r_dot_total <= '0;
    end else if (o_ram_we && (o_ram_wdata == TILE_W'(TILE_DOT) ||
                              o_ram_wdata == TILE_W'(TILE_POWER))) begin
      r_dot_total <= r_dot_total + ADDR_W'(1);
    end
  end

  assign o_dot_total = r_dot_total;
`endif

endmodule

// File: tb/tb_board_reloader.sv
// Randomized bench for board_reloader: behavioural ROM/RAM, a per-copy
// reference of the expected write stream, done timing and map selection.
module tb_board_reloader;

  localparam int BW = 28, BH = 31, TW = 4, NM = 2;
  localparam int N = BW * BH, AW = 10, RAW = 11, ROM_SZ = NM * N;

  logic          clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic [7:0]    level = 8'd0;
  logic [RAW-1:0] rom_addr;
  logic [TW-1:0] rom_data;
  logic          we, done, busy;
  logic [AW-1:0] waddr;
  logic [TW-1:0] wdata;
`ifdef BOARD_RELOADER_DOT_COUNT_EN
  logic [AW-1:0] dot_total;
`endif

  int n_chk = 0, n_fail = 0;
  logic [TW-1:0] rom [ROM_SZ];
  logic [TW-1:0] ram [N];
  logic          ram_clr = 1'b0;

  always #5 clk = ~clk;

  board_reloader dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_board_reload      (req),
    .i_level             (level),
    .o_rom_addr          (rom_addr),
    .i_rom_data          (rom_data),
    .o_ram_we            (we),
    .o_ram_addr          (waddr),
    .o_ram_wdata         (wdata),
    .o_board_reload_done (done),
    .o_busy              (busy)
`ifdef BOARD_RELOADER_DOT_COUNT_EN
    ,
    .o_dot_total         (dot_total)
`endif
  );

  // Maze ROM with a one-cycle registered read, and the board RAM.
  always @(posedge clk) begin
    rom_data <= (int'(rom_addr) < ROM_SZ) ? rom[rom_addr] : '0;
    if (ram_clr) begin
      for (int i = 0; i < N; i++) ram[i] <= 4'hF;
    end else if (we) begin
      ram[waddr] <= wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Map 0: exactly 240 dots and 4 power pellets, shuffled; map 1: any codes.
  task automatic build_rom();
    int v, j;
    logic [TW-1:0] t;
    for (int i = 0; i < N; i++) begin
      if (i < 240) rom[i] = 4'd2;
      else if (i < 244) rom[i] = 4'd3;
      else begin
        v = $urandom_range(0, 2);
        rom[i] = (v == 2) ? 4'd4 : TW'(v);
      end
    end
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = rom[i]; rom[i] = rom[j]; rom[j] = t;
    end
    for (int i = N; i < ROM_SZ; i++) rom[i] = TW'($urandom_range(0, 4));
  endtask

  // One request; abort_at >= 0 drops the request once that write appears.
  task automatic run_copy(input logic [7:0] lvl, input int abort_at, input bit wiggle,
                          input string tag);
    int map, base, c, nw, addr_err, seq_err, data_err, busy_err, ram_err;
    int done_cyc, hold, late_we, late_done, drop_c, exp_dots;
    bit dropped, exp_busy;
    map  = (lvl == 8'd0) ? 0 : (int'(lvl) - 1) % NM;
    base = map * N;
    exp_dots = 0;
    for (int i = 0; i < N; i++)
      if (rom[base + i] == 4'd2 || rom[base + i] == 4'd3) exp_dots++;
    @(negedge clk); ram_clr = 1'b1;
    @(negedge clk); ram_clr = 1'b0; level = lvl; req = 1'b1;
    @(posedge clk);
    c = 0; nw = 0; addr_err = 0; seq_err = 0; data_err = 0; busy_err = 0;
    done_cyc = -1; hold = 0; late_we = 0; late_done = 0; drop_c = 0; dropped = 0;
    while (c < N + 60) begin
      @(negedge clk);
      if (wiggle) level = 8'($urandom);
      if (!dropped && c < N && rom_addr !== RAW'(base + c)) addr_err++;
      if (we === 1'b1) begin
        if (dropped) late_we++;
        else begin
          if (waddr !== AW'(nw) || c != nw + 2) seq_err++;
          if (nw >= N || wdata !== rom[base + nw]) data_err++;
          nw++;
        end
      end
      exp_busy = !dropped && (abort_at >= 0 || c <= N + 1);
      if (busy !== exp_busy) busy_err++;
      if (done === 1'b1) begin
        if (dropped) late_done++;
        else begin
          if (done_cyc < 0) begin
            done_cyc = c;
`ifdef BOARD_RELOADER_DOT_COUNT_EN
            chk({tag, ".dots_rise"}, 32'(dot_total), 32'(exp_dots));
`endif
          end
          hold++;
        end
      end
      if (!dropped && abort_at >= 0 && we === 1'b1 && waddr == AW'(abort_at)) begin
        req = 1'b0; dropped = 1; drop_c = c;
      end
      if (!dropped && abort_at < 0 && hold == 21) begin
`ifdef BOARD_RELOADER_DOT_COUNT_EN
        chk({tag, ".dots_hold"}, 32'(dot_total), 32'(exp_dots));
`endif
        req = 1'b0; dropped = 1; drop_c = c;
      end
      if (dropped && c >= drop_c + 10) break;
      c++;
    end
    req = 1'b0;
    chk({tag, ".dropped"}, 32'(dropped), 1);
    chk({tag, ".rom_addr"}, addr_err, 0);
    chk({tag, ".wr_seq"}, seq_err, 0);
    chk({tag, ".wr_data"}, data_err, 0);
    chk({tag, ".busy"}, busy_err, 0);
    chk({tag, ".late_we"}, late_we, 0);
    chk({tag, ".late_done"}, late_done, 0);
    if (abort_at >= 0) begin
      chk({tag, ".n_writes"}, nw, abort_at + 1);
      chk({tag, ".done_cyc"}, done_cyc, -1);
    end else begin
      chk({tag, ".n_writes"}, nw, N);
      chk({tag, ".done_cyc"}, done_cyc, N + 2);
      chk({tag, ".done_hold"}, hold, 21);
      ram_err = 0;
      for (int i = 0; i < N; i++) if (ram[i] !== rom[base + i]) ram_err++;
      chk({tag, ".ram"}, ram_err, 0);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 0);
    chk({tag, ".we"}, 32'(we), 0);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wdata"}, 32'(wdata), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
`ifdef BOARD_RELOADER_DOT_COUNT_EN
    chk({tag, ".dots"}, 32'(dot_total), 0);
`endif
  endtask

  initial begin
    build_rom();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    run_copy(8'd1, -1, 1'b0, "lvl1");
    run_copy(8'd2, -1, 1'b0, "lvl2");
    run_copy(8'd3, -1, 1'b1, "lvl3_wiggle");
    run_copy(8'd0, -1, 1'b0, "lvl0");
    run_copy(8'd1, 400, 1'b0, "abort400");
    run_copy(8'd1, -1, 1'b0, "rerun");
    run_copy(8'($urandom), $urandom_range(0, N - 1), 1'b1, "rand_abort");
    run_copy(8'($urandom), -1, 1'b1, "rand_full");

    // Asynchronous reset in the middle of a copy.
    @(negedge clk); level = 8'd2; req = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_copy(8'd2, -1, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
